// File: rtl/cacheline_mem_arbiter_if.sv
// Bundle of cacheline requester signals and the burst DRAM port.
// The environment (caches + memory model) uses master, the arbiter uses slave.
interface cacheline_mem_arbiter_if #(
    parameter int CHANNELS = 2
);
    logic [CHANNELS-1:0][31:0]  req_addr;
    logic [CHANNELS-1:0]        req_read;
    logic [CHANNELS-1:0]        req_write;
    logic [CHANNELS-1:0][255:0] req_wdata;
    logic [CHANNELS-1:0][255:0] req_rdata;
    logic [CHANNELS-1:0]        req_resp;

    logic [31:0] bmem_addr;
    logic        bmem_read;
    logic        bmem_write;
    logic [63:0] bmem_wdata;
    logic        bmem_ready;
    logic [31:0] bmem_raddr;
    logic [63:0] bmem_rdata;
    logic        bmem_rvalid;

    modport master (
        output req_addr, req_read, req_write, req_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        input  req_rdata, req_resp,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata
    );

    modport slave (
        input  req_addr, req_read, req_write, req_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        output req_rdata, req_resp,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata
    );
endinterface

// File: rtl/cacheline_mem_arbiter.sv
// Round-robin arbiter sharing one 64-bit, 4-beat burst DRAM port among
// CHANNELS 256-bit cacheline requesters; one transaction in flight at a time.
module cacheline_mem_arbiter #(
    parameter int CHANNELS = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    cacheline_mem_arbiter_if.slave        bus
);
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int IW1   = IDX_W + 1;

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR, RESP} state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W-1:0]    r_grant;
    logic [1:0]          r_beat_cnt;
    logic [31:0]         r_addr;
    logic [3:0][63:0]    r_wdata;
    logic [3:0][63:0]    r_line;
    logic [255:0]        r_rdata;
    logic [CHANNELS-1:0] r_resp;
    logic                r_bmem_read;
    logic                r_bmem_write;
    logic [63:0]         r_bmem_wdata;

    logic [CHANNELS-1:0] w_any_req;
    logic                w_found;
    logic [IDX_W-1:0]    w_grant;
    logic [IW1-1:0]      w_idx;
    logic                w_beat_hit;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        assign w_any_req[gi]     = bus.req_read[gi] | bus.req_write[gi];
        assign bus.req_rdata[gi] = r_rdata;
    end

    // First requester at or after rr_ptr, wrapping modulo CHANNELS.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_idx = {1'b0, r_rr_ptr} + IW1'(i);
            if (w_idx >= IW1'(CHANNELS)) w_idx = w_idx - IW1'(CHANNELS);
            if (!w_found && w_any_req[w_idx[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_idx[IDX_W-1:0];
            end
        end
    end

    assign w_beat_hit = bus.bmem_rvalid && (bus.bmem_raddr == r_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_grant      <= '0;
            r_beat_cnt   <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_line       <= '0;
            r_rdata      <= '0;
            r_resp       <= '0;
            r_bmem_read  <= 1'b0;
            r_bmem_write <= 1'b0;
            r_bmem_wdata <= '0;
        end else begin
            r_resp <= '0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant    <= w_grant;
                        r_addr     <= {bus.req_addr[w_grant][31:5], 5'b0};
                        r_wdata    <= bus.req_wdata[w_grant];
                        r_beat_cnt <= '0;
                        // Write takes priority when a channel raises both.
                        if (bus.req_write[w_grant]) begin
                            r_state      <= WR;
                            r_bmem_write <= 1'b1;
                            r_bmem_wdata <= bus.req_wdata[w_grant][63:0];
                        end else begin
                            r_state     <= RD_REQ;
                            r_bmem_read <= 1'b1;
                        end
                    end
                end
                RD_REQ: begin
                    if (bus.bmem_ready) begin
                        r_bmem_read <= 1'b0;
                        r_state     <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (w_beat_hit) begin
                        r_line[r_beat_cnt] <= bus.bmem_rdata;
                        if (r_beat_cnt == 2'd3) begin
                            r_rdata         <= {bus.bmem_rdata, r_line[2], r_line[1], r_line[0]};
                            r_beat_cnt      <= '0;
                            r_resp[r_grant] <= 1'b1;
                            r_state         <= RESP;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 2'd1;
                        end
                    end
                end
                WR: begin
                    if (bus.bmem_ready) begin
                        if (r_beat_cnt == 2'd3) begin
                            r_bmem_write    <= 1'b0;
                            r_bmem_wdata    <= '0;
                            r_beat_cnt      <= '0;
                            r_resp[r_grant] <= 1'b1;
                            r_state         <= RESP;
                        end else begin
                            r_beat_cnt   <= r_beat_cnt + 2'd1;
                            r_bmem_wdata <= r_wdata[r_beat_cnt + 2'd1];
                        end
                    end
                end
                RESP: begin
                    if (r_grant == IDX_W'(CHANNELS - 1)) r_rr_ptr <= '0;
                    else                                 r_rr_ptr <= r_grant + 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_resp   = r_resp;
    assign bus.bmem_addr  = r_addr;
    assign bus.bmem_read  = r_bmem_read;
    assign bus.bmem_write = r_bmem_write;
    assign bus.bmem_wdata = r_bmem_wdata;
endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Directed bench for cacheline_mem_arbiter: reads, writes with stalls,
// round-robin order, stray read beats and reset in the middle of a burst.
module tb_cacheline_mem_arbiter;
    localparam int CH = 2;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    logic [255:0] last_line;

    cacheline_mem_arbiter_if #(.CHANNELS(CH)) bus ();

    cacheline_mem_arbiter #(.CHANNELS(CH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("vec %0d %s obs=%0h exp=%0h", n_vec, tag, obs, exp);
    endtask

    // Caller has raised req_read[ch] in the current (IDLE) cycle.
    task automatic run_read(input int ch, input logic [31:0] addr, input logic [63:0] pat,
                            input int stalls, input int stray_at);
        logic [31:0]  exp_addr;
        logic [255:0] exp_line;
        exp_addr = addr & 32'hFFFF_FFE0;
        for (int k = 0; k < 4; k++) exp_line[64*k +: 64] = pat * 64'(k + 1);
        bus.bmem_ready = 1'b0;
        tick();
        for (int s = 0; s <= stalls; s++) begin
            chk("rd_req_read", 256'(bus.bmem_read), 256'(1'b1));
            chk("rd_req_addr", 256'(bus.bmem_addr), 256'(exp_addr));
            chk("rd_req_nowrite", 256'(bus.bmem_write), 256'(1'b0));
            chk("rd_req_noresp", 256'(bus.req_resp), 256'(0));
            bus.bmem_ready = (s == stalls);
            tick();
        end
        bus.bmem_ready = 1'b0;
        chk("rd_wait_read_low", 256'(bus.bmem_read), 256'(1'b0));
        for (int k = 0; k < 4; k++) begin
            if (k == stray_at) begin
                bus.bmem_rvalid = 1'b1;
                bus.bmem_raddr  = 32'h0000_9990;
                bus.bmem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
                tick();
                chk("rd_stray_noresp", 256'(bus.req_resp), 256'(0));
            end
            bus.bmem_rvalid = 1'b1;
            bus.bmem_raddr  = exp_addr;
            bus.bmem_rdata  = pat * 64'(k + 1);
            tick();
            if (k < 3) chk("rd_beat_noresp", 256'(bus.req_resp), 256'(0));
        end
        bus.bmem_rvalid = 1'b0;
        chk("rd_resp", 256'(bus.req_resp), 256'(1 << ch));
        for (int c = 0; c < CH; c++) chk("rd_line", bus.req_rdata[c], exp_line);
        last_line = exp_line;
        bus.req_read[ch] = 1'b0;
        tick();
        chk("rd_resp_pulse", 256'(bus.req_resp), 256'(0));
    endtask

    // Caller has raised req_write[ch] in the current (IDLE) cycle.
    task automatic run_write(input int ch, input logic [31:0] addr, input logic [255:0] line,
                             input bit stall_first);
        bus.bmem_ready = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k == 0 && stall_first) begin
                chk("wr_stall_wdata", 256'(bus.bmem_wdata), 256'(line[63:0]));
                bus.bmem_ready = 1'b0;
                tick();
            end
            chk("wr_write", 256'(bus.bmem_write), 256'(1'b1));
            chk("wr_noread", 256'(bus.bmem_read), 256'(1'b0));
            chk("wr_addr", 256'(bus.bmem_addr), 256'(addr));
            chk("wr_wdata", 256'(bus.bmem_wdata), 256'(line[64*k +: 64]));
            chk("wr_noresp", 256'(bus.req_resp), 256'(0));
            bus.bmem_ready = 1'b1;
            tick();
        end
        chk("wr_resp", 256'(bus.req_resp), 256'(1 << ch));
        chk("wr_write_low", 256'(bus.bmem_write), 256'(1'b0));
        bus.req_write[ch] = 1'b0;
        tick();
        chk("wr_resp_pulse", 256'(bus.req_resp), 256'(0));
    endtask

    initial begin
        logic [255:0] wline;
        n_vec = 0;
        n_err = 0;
        last_line = '0;
        rst = 1'b1;
        bus.req_addr = '0;
        bus.req_read = '0;
        bus.req_write = '0;
        bus.req_wdata = '0;
        bus.bmem_ready = 1'b0;
        bus.bmem_raddr = '0;
        bus.bmem_rdata = '0;
        bus.bmem_rvalid = 1'b0;
        tick();
        tick();
        chk("rst_resp", 256'(bus.req_resp), 256'(0));
        chk("rst_read", 256'(bus.bmem_read), 256'(1'b0));
        chk("rst_write", 256'(bus.bmem_write), 256'(1'b0));
        chk("rst_addr", 256'(bus.bmem_addr), 256'(0));
        chk("rst_wdata", 256'(bus.bmem_wdata), 256'(0));
        chk("rst_rdata", bus.req_rdata[0], 256'(0));
        rst = 1'b0;
        tick();

        // Single read on ch0; resp lands in cycle 6.
        bus.req_addr[0] = 32'h0000_1234;
        bus.req_read[0] = 1'b1;
        run_read(0, 32'h0000_1234, 64'h1111_1111_1111_1111, 0, 4);

        // Single write on ch1 with the first beat held once.
        wline = {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002,
                 64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000};
        bus.req_addr[1]  = 32'h8000_0040;
        bus.req_wdata[1] = wline;
        bus.req_write[1] = 1'b1;
        run_write(1, 32'h8000_0040, wline, 1'b1);
        chk("rdata_stable_after_wr", bus.req_rdata[1], last_line);

        // Simultaneous ch0 read / ch1 write straight out of reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wline = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
        bus.req_addr[0]  = 32'h0000_2000;
        bus.req_read[0]  = 1'b1;
        bus.req_addr[1]  = 32'h0000_3000;
        bus.req_wdata[1] = wline;
        bus.req_write[1] = 1'b1;
        run_read(0, 32'h0000_2000, 64'h0202_0202_0202_0202, 0, 4);
        // ch0 re-requests at once; rr_ptr=1 so ch1 goes next.
        bus.req_addr[0] = 32'h0000_2100;
        bus.req_read[0] = 1'b1;
        run_write(1, 32'h0000_3000, wline, 1'b0);
        chk("rdata_stable_rr", bus.req_rdata[0], last_line);
        run_read(0, 32'h0000_2100, 64'h0303_0303_0303_0303, 0, 4);

        // Stray beat with foreign raddr mid-burst.
        bus.req_addr[0] = 32'h0000_4467;
        bus.req_read[0] = 1'b1;
        run_read(0, 32'h0000_4467, 64'h0101_0101_0101_0101, 0, 2);

        // Read request held through three not-ready cycles.
        bus.req_addr[1] = 32'h0000_5510;
        bus.req_read[1] = 1'b1;
        run_read(1, 32'h0000_5510, 64'h0505_0505_0505_0505, 3, 4);

        // Reset after write beat 1, then a fresh write restarts at beat 0.
        wline = {64'hB3, 64'hB2, 64'hB1, 64'hB0};
        bus.req_addr[1]  = 32'h0000_6600;
        bus.req_wdata[1] = wline;
        bus.req_write[1] = 1'b1;
        bus.bmem_ready   = 1'b1;
        tick();
        chk("rstwr_beat0", 256'(bus.bmem_wdata), 256'(64'hB0));
        tick();
        chk("rstwr_beat1", 256'(bus.bmem_wdata), 256'(64'hB1));
        tick();
        rst = 1'b1;
        bus.req_write[1] = 1'b0;
        tick();
        chk("rstwr_write_low", 256'(bus.bmem_write), 256'(1'b0));
        chk("rstwr_read_low", 256'(bus.bmem_read), 256'(1'b0));
        chk("rstwr_noresp", 256'(bus.req_resp), 256'(0));
        rst = 1'b0;
        wline = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
        bus.req_wdata[1] = wline;
        bus.req_write[1] = 1'b1;
        run_write(1, 32'h0000_6600, wline, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
